// File: rtl/mimo_pkg.sv
// mimo_pkg: shared sizes and sample/vector/matrix types for the MIMO datapath
package mimo_pkg;
    localparam int DATA_W = 32;
    localparam int N      = 4;
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    typedef logic signed [DATA_W-1:0] sample_t;
    typedef sample_t [0:N-1] vec_t;
    typedef vec_t [0:N-1] mat_t;
    typedef logic [IDX_W-1:0] idx_t;
    localparam idx_t LAST_IDX = idx_t'(N - 1);
endpackage

// File: rtl/transpose_bank.sv
// transpose_bank: one N x N sample bank, written a row at a time, read a column at a time
//   clk      rising-edge clock
//   reset    asynchronous active-low reset, clears every element
//   we       write enable for wr_data into row wr_row
//   wr_row   row index written
//   wr_data  row contents, wr_data[j] lands in element [wr_row][j]
//   rd_col   column index read
//   rd_data  column contents, rd_data[i] = element [i][rd_col]
module transpose_bank
    import mimo_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic we,
    input  idx_t wr_row,
    input  vec_t wr_data,
    input  idx_t rd_col,
    output vec_t rd_data
);
    mat_t mem;
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            mem <= '0;
        else if (we)
            mem[wr_row] <= wr_data;
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N; i++)
            rd_data[i] = mem[i][rd_col];
    end
endmodule

// File: rtl/transpose_stream.sv
// transpose_stream: ping-pong corner-turn, N row beats in, N column beats of the transpose out
//   clk        rising-edge clock
//   reset      asynchronous active-low reset, discards all stored matrices
//   in_row     row beat, in_row[j] = M[r][j]
//   in_valid   in_row holds a valid beat
//   in_ready   a beat can be accepted this cycle
//   out_col    column beat, out_col[i] = M[i][c]
//   out_valid  out_col holds a valid beat
//   out_ready  downstream accepts a beat this cycle
//   out_last   marks column N-1 of a matrix
module transpose_stream
    import mimo_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  vec_t in_row,
    input  logic in_valid,
    output logic in_ready,
    output vec_t out_col,
    output logic out_valid,
    input  logic out_ready,
    output logic out_last
);
    logic [1:0] full, full_nxt;
    logic       wr_bank, rd_bank;
    idx_t       wr_row, rd_col;
    vec_t       col0, col1;
    logic       wr, rd, wr_done, rd_done;
    assign in_ready  = !full[wr_bank];
    assign out_valid = full[rd_bank];
    assign out_last  = out_valid && rd_col == LAST_IDX;
    assign wr        = in_valid && in_ready;
    assign rd        = out_valid && out_ready;
    assign wr_done   = wr && wr_row == LAST_IDX;
    assign rd_done   = rd && rd_col == LAST_IDX;
    // out_col is a mux of bank registers under registered selects, so input never reaches output in the same cycle
    assign out_col   = rd_bank ? col1 : col0;
    transpose_bank u_bank0 (
        .clk     (clk),
        .reset   (reset),
        .we      (wr && !wr_bank),
        .wr_row  (wr_row),
        .wr_data (in_row),
        .rd_col  (rd_col),
        .rd_data (col0)
    );
    transpose_bank u_bank1 (
        .clk     (clk),
        .reset   (reset),
        .we      (wr && wr_bank),
        .wr_row  (wr_row),
        .wr_data (in_row),
        .rd_col  (rd_col),
        .rd_data (col1)
    );
    // a full bank blocks writes, so completing a write and a read together always touch different flags
    always_comb begin
        full_nxt = full;
        if (wr_done)
            full_nxt[wr_bank] = 1'b1;
        if (rd_done)
            full_nxt[rd_bank] = 1'b0;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_row  <= '0;
            rd_col  <= '0;
        end else begin
            full <= full_nxt;
            if (wr) begin
                wr_row  <= wr_done ? '0 : wr_row + idx_t'(1);
                wr_bank <= wr_bank ^ wr_done;
            end
            if (rd) begin
                rd_col  <= rd_done ? '0 : rd_col + idx_t'(1);
                rd_bank <= rd_bank ^ rd_done;
            end
        end
endmodule

// File: tb/tb_transpose_stream.sv
// tb_transpose_stream: directed self-checking bench for the streaming transpose
module tb_transpose_stream;
    import mimo_pkg::*;
    logic clk, reset, in_valid, in_ready, out_valid, out_ready, out_last;
    vec_t in_row, out_col;
    int checks = 0;
    int errors = 0;
    vec_t exp_q[$];
    vec_t cur[0:N-1];
    int wcnt = 0;
    transpose_stream dut (
        .clk       (clk),
        .reset     (reset),
        .in_row    (in_row),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_col   (out_col),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    function automatic vec_t mk(input int base, input int r);
        vec_t v;
        for (int j = 0; j < N; j++) v[j] = sample_t'(base + 10 * r + j);
        return v;
    endfunction
    function automatic vec_t colv(input int base, input int c);
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = sample_t'(base + 10 * i + c);
        return v;
    endfunction
    // one clock: drive inputs, observe pre-edge outputs, advance the transpose model on accepted rows
    task automatic cyc(input logic iv, input vec_t r, input logic ordy,
                       output logic wr, output logic rd, output logic v, output vec_t col, output logic last);
        in_valid = iv;
        in_row = r;
        out_ready = ordy;
        #0;
        wr = iv && in_ready;
        v = out_valid;
        rd = out_valid && ordy;
        col = out_col;
        last = out_last;
        if (wr) begin
            cur[wcnt] = r;
            wcnt++;
            if (wcnt == N) begin
                for (int c = 0; c < N; c++) begin
                    vec_t t;
                    for (int i = 0; i < N; i++) t[i] = cur[i][c];
                    exp_q.push_back(t);
                end
                wcnt = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        in_row = '0;
        out_ready = 1'b0;
        #2;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
        checks++; if (out_col !== vec_t'('0)) begin errors++; $display("FAIL reset_out_col: got %h expected 0", out_col); end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL post_reset: got ready %b valid %b expected 1 0", in_ready, out_valid); end
        @(posedge clk); #1;
    endtask
    task automatic test_single();
        logic wr, rd, v, last;
        vec_t col;
        for (int r = 0; r < N; r++) begin
            cyc(1'b1, mk(0, r), 1'b1, wr, rd, v, col, last);
            checks++; if (wr !== 1'b1 || v !== 1'b0) begin errors++; $display("FAIL single_write r%0d: got wr %b valid %b expected 1 0", r, wr, v); end
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_latency: got out_valid %b expected 1", out_valid); end
        for (int c = 0; c < N; c++) begin
            cyc(1'b0, '0, 1'b1, wr, rd, v, col, last);
            void'(exp_q.pop_front());
            checks++; if (rd !== 1'b1 || col !== colv(0, c)) begin errors++; $display("FAIL single_col c%0d: got rd %b %h expected 1 %h", c, rd, col, colv(0, c)); end
            checks++; if (last !== (c == N - 1)) begin errors++; $display("FAIL single_last c%0d: got %b expected %b", c, last, c == N - 1); end
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got out_valid %b expected 0", out_valid); end
    endtask
    task automatic test_back_to_back();
        logic wr, rd, v, last;
        vec_t col, e;
        int nw = 0, nr = 0, first = -1;
        for (int k = 0; k < 40 && nr < 3 * N; k++) begin
            cyc(nw < 3 * N, mk(100 * (nw / N), nw % N), 1'b1, wr, rd, v, col, last);
            if (nw < 3 * N) begin
                checks++; if (wr !== 1'b1) begin errors++; $display("FAIL b2b_in_ready k%0d: got %b expected 1", k, wr); end
                nw++;
            end
            if (rd) begin
                if (first < 0) first = k;
                e = exp_q.pop_front();
                checks++; if (col !== e || k != first + nr) begin errors++; $display("FAIL b2b_col n%0d cyc%0d: got %h expected %h at cyc %0d", nr, k, col, e, first + nr); end
                checks++; if (last !== (nr % N == N - 1)) begin errors++; $display("FAIL b2b_last n%0d: got %b expected %b", nr, last, nr % N == N - 1); end
                nr++;
            end
        end
        checks++; if (nr != 3 * N || first != N) begin errors++; $display("FAIL b2b_count: got %0d beats first %0d expected %0d first %0d", nr, first, 3 * N, N); end
    endtask
    task automatic test_backpressure();
        logic wr, rd, v, last;
        vec_t col, e;
        int nw = 0, nr = 0;
        for (int k = 0; k < 2 * N + 3; k++) begin
            cyc(1'b1, mk(1000 + 100 * (nw / N), nw % N), 1'b0, wr, rd, v, col, last);
            checks++; if (wr !== (k < 2 * N)) begin errors++; $display("FAIL bp_fill k%0d: got wr %b expected %b", k, wr, k < 2 * N); end
            if (wr) nw++;
        end
        for (int c = 0; c < N; c++) begin
            cyc(1'b1, mk(1000 + 100 * (nw / N), nw % N), 1'b1, wr, rd, v, col, last);
            e = exp_q.pop_front();
            checks++; if (wr !== 1'b0 || rd !== 1'b1 || col !== e) begin errors++; $display("FAIL bp_drain c%0d: got wr %b rd %b %h expected 0 1 %h", c, wr, rd, col, e); end
            checks++; if (last !== (c == N - 1)) begin errors++; $display("FAIL bp_last c%0d: got %b expected %b", c, last, c == N - 1); end
            nr++;
        end
        for (int k = 0; k < 40 && nr < 3 * N; k++) begin
            cyc(nw < 3 * N, mk(1000 + 100 * (nw / N), nw % N), 1'b1, wr, rd, v, col, last);
            if (k == 0) begin
                checks++; if (wr !== 1'b1) begin errors++; $display("FAIL bp_ready_return: got %b expected 1", wr); end
            end
            if (wr) nw++;
            if (rd) begin
                e = exp_q.pop_front();
                checks++; if (col !== e) begin errors++; $display("FAIL bp_col n%0d: got %h expected %h", nr, col, e); end
                nr++;
            end
        end
        checks++; if (nr != 3 * N || nw != 3 * N) begin errors++; $display("FAIL bp_count: got %0d reads %0d writes expected %0d", nr, nw, 3 * N); end
    endtask
    task automatic test_stall_hold();
        logic wr, rd, v, last;
        vec_t col;
        for (int r = 0; r < N; r++) cyc(1'b1, mk(0, r), 1'b0, wr, rd, v, col, last);
        cyc(1'b0, '0, 1'b1, wr, rd, v, col, last);
        void'(exp_q.pop_front());
        checks++; if (col !== colv(0, 0)) begin errors++; $display("FAIL stall_col0: got %h expected %h", col, colv(0, 0)); end
        for (int s = 0; s < 5; s++) begin
            cyc(1'b0, '0, 1'b0, wr, rd, v, col, last);
            checks++; if (v !== 1'b1 || col !== colv(0, 1) || last !== 1'b0) begin errors++; $display("FAIL stall_hold s%0d: got v %b %h last %b expected 1 %h 0", s, v, col, last, colv(0, 1)); end
        end
        for (int c = 1; c < N; c++) begin
            cyc(1'b0, '0, 1'b1, wr, rd, v, col, last);
            void'(exp_q.pop_front());
            checks++; if (rd !== 1'b1 || col !== colv(0, c) || last !== (c == N - 1)) begin errors++; $display("FAIL stall_resume c%0d: got rd %b %h last %b expected 1 %h", c, rd, col, last, colv(0, c)); end
        end
    endtask
    task automatic test_input_gaps();
        logic wr, rd, v, last;
        vec_t col, e;
        int nw = 0, nr = 0;
        for (int k = 0; k < 200 && nr < 2 * N; k++) begin
            cyc(nw < 2 * N && k % 2 == 0, mk(-1000 + 500 * (nw / N), nw % N), 1'($urandom_range(0, 1)), wr, rd, v, col, last);
            if (wr) nw++;
            if (rd) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL gaps_extra n%0d: got %h expected no beat", nr, col); end
                else begin
                    e = exp_q.pop_front();
                    if (col !== e) begin errors++; $display("FAIL gaps_col n%0d: got %h expected %h", nr, col, e); end
                end
                nr++;
            end
        end
        checks++; if (nr != 2 * N || exp_q.size() != 0) begin errors++; $display("FAIL gaps_count: got %0d beats %0d left expected %0d 0", nr, exp_q.size(), 2 * N); end
    endtask
    task automatic test_reset_mid();
        logic wr, rd, v, last;
        vec_t col;
        for (int r = 0; r < N + 2; r++) cyc(1'b1, mk(500, r % N), 1'b0, wr, rd, v, col, last);
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_col !== vec_t'('0)) begin errors++; $display("FAIL rst_mid: got v %b rdy %b %h expected 0 1 0", out_valid, in_ready, out_col); end
        exp_q.delete();
        wcnt = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int r = 0; r < N; r++) begin
            cyc(1'b1, mk(200, r), 1'b1, wr, rd, v, col, last);
            checks++; if (wr !== 1'b1 || v !== 1'b0) begin errors++; $display("FAIL rst_rewrite r%0d: got wr %b v %b expected 1 0", r, wr, v); end
        end
        for (int c = 0; c < N; c++) begin
            cyc(1'b0, '0, 1'b1, wr, rd, v, col, last);
            void'(exp_q.pop_front());
            checks++; if (rd !== 1'b1 || col !== colv(200, c)) begin errors++; $display("FAIL rst_col c%0d: got rd %b %h expected 1 %h", c, rd, col, colv(200, c)); end
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_empty: got out_valid %b expected 0", out_valid); end
    endtask
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_stall_hold();
        test_input_gaps();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

// File: doc/transpose_stream.md
Name: transpose_stream

Overview:
- Streaming corner-turn buffer: accepts a 4x4 matrix of signed samples one row per beat and emits its transpose one column per beat.
- It is the serial counterpart to the team's parallel transpose. Upstream writers produce row beats; downstream consumers read column beats, e.g. channel-matrix H -> H^T ahead of the MIMO multiply stage.
- Ping-pong (two banks) so that a continuous stream runs at one beat per cycle.

Parameters:
- DATA_W, 32, bit width of each signed element
- N, 4, matrix dimension (rows = columns = beats per matrix)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (asserts on low, no clock needed)
- in_row  input  N x DATA_W signed  row beat; in_row[j] = M[r][j]
- in_valid  input  1  in_row holds a valid beat
- in_ready  output  1  block can accept a beat this cycle
- out_col  output  N x DATA_W signed  column beat; out_col[i] = M[i][c]
- out_valid  output  1  out_col holds a valid beat
- out_ready  input  1  downstream accepts a beat this cycle
- out_last  output  1  high with the final column (c = N-1) of a matrix

Behaviour:
- Storage: two banks (bank0, bank1), each N x N x DATA_W.
- Control state:
  - full[1:0] flags
  - wr_bank and wr_row counter (0..N-1)
  - rd_bank and rd_col counter (0..N-1)
- Reset (reset low, asynchronous): all storage 0, full = 0, wr_bank = rd_bank = 0, wr_row = rd_col = 0.
  - Outputs during and after reset: in_ready = 1, out_valid = 0, out_last = 0, out_col = 0.
- Write handshake: in_ready = !full[wr_bank]. A write occurs when in_valid && in_ready.
  - On a write: bank[wr_bank][wr_row][*] <= in_row; wr_row increments.
  - When wr_row = N-1 on a write: wr_row <= 0, full[wr_bank] <= 1, wr_bank toggles.
- Read handshake: out_valid = full[rd_bank]. A read occurs when out_valid && out_ready.
  - out_col[i] = bank[rd_bank][i][rd_col], driven from registers; there is no combinational in->out path.
  - On a read: rd_col increments.
  - When rd_col = N-1 on a read: rd_col <= 0, full[rd_bank] <= 0, rd_bank toggles.
- out_last = out_valid && (rd_col == N-1).
- Latency: the last row is accepted at edge t; out_valid is high from cycle t+1. Minimum first-row-in to first-column-out is N cycles.
- Throughput: 1 beat/cycle sustained with in_valid and out_ready held high. in_ready never drops in that case.
- Both banks full: in_ready = 0 until the read side completes a bank. in_ready returns in the cycle after the last column of that bank is read (registered full flag).
- Simultaneous write completion and read completion in the same cycle:
  - The two always target different banks, because a full bank blocks writes.
  - Both flag updates apply in that cycle.
- Output hold: while out_valid && !out_ready, out_col, out_valid, and out_last hold stable.
- Input ignore: when in_ready = 0, in_row is ignored and no state changes.
- Partial matrix (wr_row > 0): out_valid is unaffected. A partial bank is never readable.
- Reset mid-operation: partial and full matrices are discarded with no output. The next accepted beat is row 0 of bank0.
- Arithmetic: none. Values pass bit-exact, including sign, for any DATA_W.

Decomposition:
- Shared package mimo_pkg holds:
  - localparam DATA_W = 32 and N = 4
  - typedef sample_t (logic signed [DATA_W-1:0])
  - typedef vec_t (sample_t [0:N-1])
  - typedef mat_t (vec_t [0:N-1])
- One sub-module, transpose_bank: a single N x N register bank.
  - Ports: row write (we, row index, vec_t data) and column read (col index -> vec_t).
  - Asynchronous active-low reset.
  - Instantiated twice; the ping-pong control stays in the top level.

Test Plan:
- Single matrix: write rows with M[r][j] = 10r+j, out_ready = 1 -> columns {0,10,20,30}, {1,11,21,31}, {2,12,22,32}, {3,13,23,33}; out_last only on the 4th; first out_valid one cycle after row 3 is accepted.
- Back-to-back: 3 matrices with in_valid and out_ready continuously high (second matrix = first + 100) -> in_ready never low, 12 column beats on consecutive cycles, values correct per matrix.
- Backpressure: out_ready = 0 while writing 2 full matrices plus row 0 of a third -> in_ready drops after the 8th row; raising out_ready drains bank0; in_ready returns the cycle after column 3 is read; the third matrix then completes correctly.
- Stall hold: drop out_ready for 5 cycles mid-matrix at rd_col = 1 -> out_col holds {1,11,21,31} and out_valid stays 1 throughout.
- Input gaps: in_valid toggles 1/0 per cycle with out_ready random at 50% -> the output sequence matches the golden model and no beat is duplicated or dropped.
- Reset mid-operation: pull reset low after 2 rows and 1 full matrix, with out_ready = 0 -> in the same cycle out_valid = 0, in_ready = 1, out_col = 0; the next 4 rows written (values 200+) emit as the first matrix.
